// File: rtl/target_uart_trigger_if.sv
// Bus bundle for target_uart_trigger: target UART line, arm/disarm control,
// match configuration and the trigger/status outputs.
interface target_uart_trigger_if;
  logic        target_rx;
  logic        arm;
  logic        disarm;
  logic [31:0] pattern;
  logic [2:0]  pattern_len;
  logic [31:0] timeout;
  logic        trigger;
  logic        timed_out;
  logic        armed;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport master (
    output target_rx, arm, disarm, pattern, pattern_len, timeout,
    input  trigger, timed_out, armed, rx_data, rx_valid
  );

  modport slave (
    input  target_rx, arm, disarm, pattern, pattern_len, timeout,
    output trigger, timed_out, armed, rx_data, rx_valid
  );
endinterface

// File: rtl/target_uart_trigger.sv
// Target-side glitch trigger: 8N1 UART receiver on the target TX line plus an
// arm/disarm matcher that fires a one-cycle trigger on a 1-4 byte pattern.
module target_uart_trigger #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst_n,
  target_uart_trigger_if.slave   bus
);

  localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {IDLE, ARMED} ctl_state_t;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    if (len == 3'd0)      return 3'd1;
    else if (len > 3'd4)  return 3'd4;
    else                  return len;
  endfunction

  function automatic logic [31:0] len_mask(input logic [2:0] len);
    case (len)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      3'd3:    return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Synchroniser; r_rx_prev gives the 1->0 start-edge detect
  logic [1:0] r_sync;
  logic       r_rx_prev;
  logic       w_rx_s;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], bus.target_rx};
      r_rx_prev <= w_rx_s;
    end
  end

  // Receiver FSM
  rx_state_t   r_rx_state, w_rx_state_next;
  logic [15:0] r_clk_cnt, w_clk_cnt_next;
  logic [2:0]  r_bit_idx, w_bit_idx_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        w_byte_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_clk_cnt  <= w_clk_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_clk_cnt_next  = r_clk_cnt + 16'd1;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_byte_ok       = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_clk_cnt_next = '0;
        if (r_rx_prev && !w_rx_s) w_rx_state_next = RX_START;
      end
      RX_START: begin
        if (r_clk_cnt == LP_HALF_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_rx_state_next = w_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == LP_BIT_LAST) begin
          w_clk_cnt_next = '0;
          w_shift_next   = {w_rx_s, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == LP_BIT_LAST) begin
          w_clk_cnt_next  = '0;
          w_byte_ok       = w_rx_s;
          w_rx_state_next = RX_IDLE;
        end
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_byte_ok;
      if (w_byte_ok) r_rx_data <= r_shift;
    end
  end

  // Control FSM
  ctl_state_t  r_state, w_state_next;
  logic [31:0] r_pattern;
  logic [2:0]  r_len;
  logic [31:0] r_timeout;
  logic [31:0] r_hist;
  logic [2:0]  r_byte_cnt;
  logic [31:0] r_tcnt;
  logic        r_trigger, r_timed_out, r_armed;

  logic [31:0] w_hist_shift;
  logic [2:0]  w_cnt_inc;
  logic [31:0] w_tcnt_inc;
  logic        w_load, w_shift_hist, w_fire_trig, w_fire_tout, w_tcnt_en;

  assign w_hist_shift = {r_hist[23:0], r_shift};
  assign w_cnt_inc    = (r_byte_cnt == 3'd4) ? 3'd4 : r_byte_cnt + 3'd1;
  assign w_tcnt_inc   = r_tcnt + 32'd1;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift_hist = 1'b0;
    w_fire_trig  = 1'b0;
    w_fire_tout  = 1'b0;
    w_tcnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.arm && !bus.disarm) begin
          w_state_next = ARMED;
          w_load       = 1'b1;
        end
      end
      ARMED: begin
        if (bus.disarm) begin
          w_state_next = IDLE;
        end else if (bus.arm) begin
          w_load = 1'b1;
        end else if (r_trigger || r_timed_out) begin
          // Leave one cycle after the pulse so armed overlaps it
          w_state_next = IDLE;
        end else begin
          if (w_byte_ok) begin
            w_shift_hist = 1'b1;
            if ((w_cnt_inc >= r_len) &&
                (((w_hist_shift ^ r_pattern) & len_mask(r_len)) == 32'd0))
              w_fire_trig = 1'b1;
          end
          if (r_timeout != 32'd0) begin
            w_tcnt_en = 1'b1;
            if ((w_tcnt_inc == r_timeout) && !w_fire_trig) w_fire_tout = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_trigger   <= 1'b0;
      r_timed_out <= 1'b0;
      r_pattern   <= '0;
      r_len       <= 3'd1;
      r_timeout   <= '0;
      r_hist      <= '0;
      r_byte_cnt  <= '0;
      r_tcnt      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_armed     <= (w_state_next == ARMED);
      r_trigger   <= w_fire_trig;
      r_timed_out <= w_fire_tout;
      if (w_load) begin
        r_pattern  <= bus.pattern;
        r_len      <= clamp_len(bus.pattern_len);
        r_timeout  <= bus.timeout;
        r_hist     <= '0;
        r_byte_cnt <= '0;
        r_tcnt     <= '0;
      end else begin
        if (w_shift_hist) begin
          r_hist     <= w_hist_shift;
          r_byte_cnt <= w_cnt_inc;
        end
        if (w_tcnt_en) r_tcnt <= w_tcnt_inc;
      end
    end
  end

  assign bus.trigger   = r_trigger;
  assign bus.timed_out = r_timed_out;
  assign bus.armed     = r_armed;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;

endmodule

// File: tb/tb_target_uart_trigger.sv
// Scoreboard bench for target_uart_trigger at CLKS_PER_BIT=16.
module tb_target_uart_trigger;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  target_uart_trigger_if bus ();

  target_uart_trigger #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       t;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_rxv    = 0;
  int n_trig   = 0;
  int n_tout   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: every rx_valid pops one expected byte and trigger flag
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) begin
        logic have;
        exp_t e;
        n_rxv++;
        if (bus.trigger) n_trig++;
        have = (sb_q.size() > 0);
        check_eq("rx_expected", 32'(have), 32'd1);
        if (have) begin
          e = sb_q.pop_front();
          check_eq("rx_data", 32'(bus.rx_data), 32'(e.d));
          check_eq("trigger_on_rx", 32'(bus.trigger), 32'(e.t));
        end
      end else if (bus.trigger) begin
        check_eq("trigger_without_rx", 32'(bus.trigger), 32'd0);
      end
      if (bus.timed_out) n_tout++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.target_rx = f[i];
      tick(CPB);
    end
    bus.target_rx = 1'b1;
    tick(CPB + 4);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic trig);
    exp_t e;
    e.d = d;
    e.t = trig;
    sb_q.push_back(e);
    send_frame(d, 1'b1);
  endtask

  task automatic do_arm(input logic [31:0] pat, input logic [2:0] len, input logic [31:0] tout);
    bus.pattern     = pat;
    bus.pattern_len = len;
    bus.timeout     = tout;
    bus.arm         = 1'b1;
    tick(1);
    bus.arm         = 1'b0;
    // Scramble config: it must only be taken on the arm cycle
    bus.pattern     = ~pat;
    bus.pattern_len = 3'd2;
    bus.timeout     = 32'd7;
  endtask

  task automatic do_disarm();
    bus.disarm = 1'b1;
    tick(1);
    bus.disarm = 1'b0;
  endtask

  initial begin
    int k;
    int n0;
    int t0;
    int o0;
    bus.target_rx   = 1'b1;
    bus.arm         = 1'b0;
    bus.disarm      = 1'b0;
    bus.pattern     = '0;
    bus.pattern_len = '0;
    bus.timeout     = '0;

    // Reset, arm, receive one byte, then reset in the middle of a frame
    tick(4);
    rst_n = 1'b1;
    tick(4);
    do_arm(32'h77, 3'd1, 32'd0);
    send_byte(8'h3A, 1'b0);
    check_eq("pre_reset_armed", 32'(bus.armed), 32'd1);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        tick(60);
        rst_n = 1'b0;
        tick(2);
        check_eq("rst_armed", 32'(bus.armed), 32'd0);
        check_eq("rst_trigger", 32'(bus.trigger), 32'd0);
        check_eq("rst_timed_out", 32'(bus.timed_out), 32'd0);
        check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      end
    join
    rst_n = 1'b1;
    tick(5);
    n0 = n_rxv;
    send_byte(8'h55, 1'b0);
    check_eq("post_reset_rx_count", n_rxv, n0 + 1);

    // Single-byte match, one-shot
    t0 = n_trig;
    do_arm(32'h0000_00A5, 3'd1, 32'd0);
    check_eq("armed_rise", 32'(bus.armed), 32'd1);
    send_byte(8'h12, 1'b0);
    send_byte(8'hA5, 1'b1);
    check_eq("single_armed_after", 32'(bus.armed), 32'd0);
    send_byte(8'hA5, 1'b0);
    check_eq("single_trig_count", n_trig, t0 + 1);

    // Multi-byte match
    do_arm(32'h00DE_ADBE, 3'd3, 32'd0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b1);

    // pattern_len 0 acts as 1, 7 acts as 4
    do_arm(32'h0000_00A5, 3'd0, 32'd0);
    send_byte(8'hA5, 1'b1);
    do_arm(32'h1122_3344, 3'd7, 32'd0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    check_eq("len7_armed_after", 32'(bus.armed), 32'd0);

    // Timeout with no traffic
    t0 = n_trig;
    o0 = n_tout;
    do_arm(32'h0000_00A5, 3'd1, 32'd1000);
    k = 0;
    while (k < 1200 && !bus.timed_out) begin
      tick(1);
      k++;
    end
    check_eq("timeout_latency", k, 1000);
    check_eq("timeout_armed_in_pulse", 32'(bus.armed), 32'd1);
    tick(1);
    check_eq("timeout_armed_fall", 32'(bus.armed), 32'd0);
    check_eq("timeout_single_pulse", 32'(bus.timed_out), 32'd0);
    check_eq("timeout_pulse_count", n_tout, o0 + 1);
    check_eq("timeout_no_trigger", n_trig, t0);

    // Arm-to-trigger latency: 2 sync + 1 edge + 8 + 8*16 + 16 cycles
    do_arm(32'h0000_00A5, 3'd1, 32'd0);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        k = 0;
        while (k < 300 && !bus.trigger) begin
          tick(1);
          k++;
        end
        check_eq("trigger_latency", k, 155);
        check_eq("armed_during_trigger", 32'(bus.armed), 32'd1);
        tick(1);
        check_eq("armed_fall_after_trigger", 32'(bus.armed), 32'd0);
      end
    join

    // Match completing on the timeout cycle: trigger only
    o0 = n_tout;
    t0 = n_trig;
    do_arm(32'h0000_00A5, 3'd1, 32'd155);
    send_byte(8'hA5, 1'b1);
    tick(10);
    check_eq("match_vs_timeout_no_tout", n_tout, o0);
    check_eq("match_vs_timeout_trig", n_trig, t0 + 1);

    // Framing error and start-bit glitch
    n0 = n_rxv;
    send_frame(8'h5A, 1'b0);
    check_eq("framing_no_rx", n_rxv, n0);
    bus.target_rx = 1'b0;
    tick(3);
    bus.target_rx = 1'b1;
    tick(200);
    check_eq("glitch_no_rx", n_rxv, n0);
    send_byte(8'hC3, 1'b0);

    // Re-arm clears history
    do_arm(32'h00DE_ADBE, 3'd3, 32'd0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    do_arm(32'h00DE_ADBE, 3'd3, 32'd0);
    send_byte(8'hBE, 1'b0);
    check_eq("rearm_still_armed", 32'(bus.armed), 32'd1);

    // Disarm mid-pattern
    o0 = n_tout;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    do_disarm();
    check_eq("disarm_armed", 32'(bus.armed), 32'd0);
    send_byte(8'hBE, 1'b0);
    check_eq("disarm_no_tout", n_tout, o0);

    // arm and disarm together, from IDLE and from ARMED
    bus.arm = 1'b1;
    bus.disarm = 1'b1;
    tick(1);
    bus.arm = 1'b0;
    bus.disarm = 1'b0;
    check_eq("arm_disarm_idle", 32'(bus.armed), 32'd0);
    do_arm(32'h0000_00A5, 3'd1, 32'd0);
    bus.arm = 1'b1;
    bus.disarm = 1'b1;
    tick(1);
    bus.arm = 1'b0;
    bus.disarm = 1'b0;
    check_eq("arm_disarm_armed", 32'(bus.armed), 32'd0);
    send_byte(8'hA5, 1'b0);

    tick(20);
    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/target_uart_trigger.md
# target_uart_trigger

Arms on command, watches the target MCU's UART transmit line (`target_rx`) and fires a one-cycle trigger when a programmed 1–4 byte pattern is received. It sits directly upstream of `offset_counter` as an alternative source of `start_offset_counter`, so the glitch offset is measured from a target-side event rather than from the host command. It also exposes the decoded byte stream and a timeout indication for status LEDs and the command processor.

## Interface
- `CLKS_PER_BIT`, default 868 — sys_clk cycles per UART bit (100 MHz / 115200); legal range 8..65535.
- `clk`  in  1  system clock (`sys_clk`, 100 MHz).
- `rst_n`  in  1  reset: asynchronous assert, active-low; all state cleared.
- `target_rx`  in  1  asynchronous target UART line, 8N1, idle high.
- `arm`  in  1  single-cycle pulse; latches configuration and starts or restarts matching.
- `disarm`  in  1  single-cycle pulse; returns the block to IDLE.
- `pattern`  in  32  match bytes; `[7:0]` = last byte received, `[15:8]` = the byte before it, and so on.
- `pattern_len`  in  3  number of bytes to match; 0 is treated as 1, values above 4 are treated as 4.
- `timeout`  in  32  cycles allowed while armed; 0 = no timeout.
- `trigger`  out  1  single-cycle pulse on a pattern match; drives `offset_counter.enable`.
- `timed_out`  out  1  single-cycle pulse when the timeout expires.
- `armed`  out  1  high while in the ARMED state.
- `rx_data`  out  8  last correctly framed byte received.
- `rx_valid`  out  1  single-cycle strobe when `rx_data` is updated.

## Operation
- **Input path:** `target_rx` passes through a 2-flop synchroniser, reset to 1, giving `rx_s`.
- **Receiver FSM (always running, independent of arming):**
  - RX_IDLE → RX_START on `rx_s` going 1→0.
  - RX_START: wait `CLKS_PER_BIT/2` cycles, then sample. If `rx_s`=1 the start bit was a glitch: return to RX_IDLE. Otherwise go to RX_DATA.
  - RX_DATA: sample every `CLKS_PER_BIT` cycles; 8 bits, LSB first.
  - RX_STOP: sample after a further `CLKS_PER_BIT` cycles. If the stop bit is 1, update `rx_data` and pulse `rx_valid`. If it is 0 (framing error), drop the byte. Either way return to RX_IDLE, which requires `rx_s`=1 before a new start bit is accepted.
- **Control FSM states:** IDLE, ARMED.
  - IDLE: `arm` latches `pattern`, the clamped `pattern_len` and `timeout`; clears the 32-bit byte history and the timeout counter; → ARMED.
  - ARMED:
    - On each `rx_valid`, the history shifts left 8 and the new byte enters `[7:0]`. A byte counter saturates at 4.
    - Match condition: byte counter ≥ len, and history equals the latched pattern over the low len bytes.
    - On a match: pulse `trigger` and go → IDLE (one-shot).
  - Timeout:
    - If the latched timeout ≠ 0, a 32-bit counter increments each ARMED cycle.
    - When it reaches the latched timeout: pulse `timed_out`, go → IDLE.
- **Priority within one cycle:**
  - `disarm` over `arm` (result IDLE, no pulses).
  - `arm` while ARMED restarts: relatch, clear history and counter, stay ARMED, suppress any same-cycle match or timeout.
  - A match and a timeout in the same cycle: match wins; `trigger` only.
- Bytes received while in IDLE are output on `rx_data`/`rx_valid` but do not enter the history.
- Configuration inputs are ignored except on the `arm` cycle.

## Timing
- **Reset values:**
  - `trigger`=0, `timed_out`=0, `armed`=0, `rx_data`=0x00, `rx_valid`=0.
  - Both FSMs idle; synchroniser flops = 1.
- `armed` rises the cycle after `arm` is sampled.
- **Receive latency:** `rx_valid` is registered, 1 cycle after the stop-bit sample. The stop-bit sample falls ≈9.5·`CLKS_PER_BIT` cycles after the synchronised start edge, plus 2 cycles of synchroniser delay.
- `trigger` asserts in the same cycle as the `rx_valid` of the completing byte. `armed` falls in the next cycle.
- **Timeout:** `timed_out` asserts when the counter equals the timeout, i.e. `timeout` cycles after `armed` rises. `armed` falls in the next cycle.
- All outputs are registered; none is combinational from inputs.
- `rst_n` deasserted mid-byte discards the partial byte; the receiver restarts in RX_IDLE.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Reset values:** assert reset mid-frame → all outputs 0; a subsequent clean byte 0x55 gives `rx_valid` once with `rx_data`=0x55.
- **Single-byte match:** arm with `pattern`=0x000000A5, `pattern_len`=1, `timeout`=0; send 0x12, then 0xA5 → exactly one `trigger`, coincident with the 0xA5 `rx_valid`; `armed`=0 afterwards; a second 0xA5 gives no trigger.
- **Multi-byte match:** arm with `pattern`=0x00DEADBE, `pattern_len`=3; send DE AD DE AD BE → `trigger` only on BE. `pattern_len`=0 behaves as 1; `pattern_len`=7 behaves as 4.
- **Timeout:** arm with `timeout`=1000 and send nothing → `timed_out` 1000 cycles after `armed` rises, no `trigger`. With the matching byte completing on the timeout cycle → `trigger` only.
- **Framing and noise:** send a byte with stop bit 0 → no `rx_valid`. Send a 3-cycle low glitch → no byte decoded.
- **Arm and disarm interactions:** re-arm after DE AD of a 3-byte pattern, then send BE → no trigger (history cleared). `disarm` mid-pattern → IDLE, no pulses. `arm` and `disarm` in the same cycle → IDLE.
